shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the overflow-capturing shifter in the
//  execute stage. It shifts one bit per cycle under a start/done handshake.
//  Each bit shifted out is captured as the overflow bit that feeds the
//  overflow input mux. The decode/control unit holds Busy-based stalls while
//  a shift is in flight.
// PARAMETERS
//  WIDTH   8  data width in bits
//  SHAMTW  3  shift-amount width in bits; max shift = 2**SHAMTW-1
// PORTS
//  CLK      in   1       single clock; all state changes on rising edge
//  ResetN   in   1       asynchronous active-low reset
//  Start    in   1       request a shift; sampled only in IDLE
//  Flush    in   1       synchronous abort; return to IDLE
//  Data     in   WIDTH   operand (register read data)
//  Shamt    in   SHAMTW  shift amount
//  Dir      in   1       0 = left, 1 = right
//  Arith    in   1       right shifts only: 1 = sign fill, 0 = zero fill
//  OvIn     in   1       overflow value passed through when Shamt = 0
//  Busy     out  1       high in SHIFT and DONE
//  Done     out  1       one-cycle pulse; Result/Ov valid
//  Result   out  WIDTH   shifted value; held until the next accepted Start
//  Ov       out  1       last bit shifted out; held with Result
// BEHAVIOUR
//  Reset: State=IDLE, Count=0, Result=0, Ov=0, Busy=0, Done=0; asynchronous on ResetN=0.
//  IDLE: Start=1 latches Data->Result, Shamt->Count, Dir, Arith.
//   - Shamt!=0 -> SHIFT.
//   - Shamt==0 -> DONE, with Ov<=OvIn.
//  SHIFT: each cycle shift Result by 1 bit, Ov<=bit shifted out, Count<=Count-1.
//   - Left shift: Ov=Result[WIDTH-1], fill LSB with 0.
//   - Right shift: Ov=Result[0], MSB fill = Arith ? Result[WIDTH-1] : 0.
//   - Count==1 on this edge -> DONE.
//  DONE: Done=1 for exactly one cycle, then IDLE.
//  Latency: Done is high in cycle Shamt+1 after the Start edge, i.e. 1..2**SHAMTW cycles.
//  Busy=1 whenever State!=IDLE; Done implies Busy.
//  Start while not IDLE is ignored; no queuing.
//  Start and Done in the same cycle: Start is ignored. A new Start is accepted only in IDLE.
//  Flush=1 in any state -> IDLE next edge. Done is not raised.
//   - Result/Ov keep their partial values. Flush has priority over Start.
//  Count is SHAMTW bits and never wraps. Decrement occurs only in SHIFT, where Count>=1.
//  ResetN deasserted mid-shift aborts immediately. Outputs return to reset values.
//  Data/Shamt/Dir/Arith may change after the Start edge; the latched copies are used.
// STRUCTURE
//  Package shift_pkg holds:
//   - typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t
//   - localparams DIR_LEFT=0, DIR_RIGHT=1
//  Sub-module shift_step: combinational single-bit shifter.
//   - Inputs: value, Dir, Arith.
//   - Outputs: next value, shifted-out bit.
//  Top holds the FSM, Count, and the Result/Ov registers.
// TESTING
//  1 Reset: ResetN=0 with random inputs -> Busy=0, Done=0, Result=0, Ov=0.
//  2 Left shift: Data=8'b1011_0001, Shamt=3, Dir=0 ->
//     Done 4 cycles after Start; Result=8'b1000_1000, Ov=1.
//  3 Arithmetic right: Data=8'h90, Shamt=2, Dir=1, Arith=1 ->
//     Result=8'hE4, Ov=0, Done at cycle 3.
//  4 Zero shift: Shamt=0, Data=8'h5A, OvIn=1 ->
//     Done 1 cycle after Start; Result=8'h5A, Ov=1.
//  5 Max shift with Start held: Shamt=7, Dir=1, Arith=0, Data=8'hFF, Start held high ->
//     Result=8'h01, Ov=1, Done at cycle 8; second op begins only after IDLE.
//  6 Aborts: Flush at cycle 2 of a Shamt=5 shift -> IDLE next cycle, no Done pulse.
//     Separately, ResetN pulse mid-shift -> all outputs 0 immediately.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared types for the execute-stage shift sequencer.
package shift_pkg;

    // Sequencer states: accept in IDLE, one bit per cycle in SHIFT, pulse in DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/Done handshake and operand/result bus between control and the sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int SHAMTW = 3
);
    logic              Start;
    logic              Flush;
    logic [WIDTH-1:0]  Data;
    logic [SHAMTW-1:0] Shamt;
    logic              Dir;
    logic              Arith;
    logic              OvIn;
    logic              Busy;
    logic              Done;
    logic [WIDTH-1:0]  Result;
    logic              Ov;

    // Control/decode side drives requests and watches Busy/Done.
    modport master (
        output Start, Flush, Data, Shamt, Dir, Arith, OvIn,
        input  Busy, Done, Result, Ov
    );

    // Sequencer side.
    modport slave (
        input  Start, Flush, Data, Shamt, Dir, Arith, OvIn,
        output Busy, Done, Result, Ov
    );
endinterface

// File: rtl/shift_sequencer_step.sv
// Combinational one-bit shifter; reports the bit that falls off the end.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] value_o,
    output logic             out_bit_o
);

    // Left fills LSB with zero; right fills MSB with sign (arith) or zero.
    always_comb begin
        value_o   = value_i;
        out_bit_o = 1'b0;
        if (dir_i == DIR_LEFT) begin
            value_o   = {value_i[WIDTH-2:0], 1'b0};
            out_bit_o = value_i[WIDTH-1];
        end else begin
            value_o   = {arith_i & value_i[WIDTH-1], value_i[WIDTH-1:1]};
            out_bit_o = value_i[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: one bit per cycle, last shifted-out bit kept as Ov.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SHAMTW = 3
) (
    input  logic              CLK,
    input  logic              ResetN,
    shift_sequencer_if.slave  bus
);

    seq_state_t        state_q, state_d;
    logic [SHAMTW-1:0] count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ov_q, ov_d;
    logic              dir_q, dir_d;
    logic              arith_q, arith_d;

    logic [WIDTH-1:0]  step_val;
    logic              step_bit;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value_i   (result_q),
        .dir_i     (dir_q),
        .arith_i   (arith_q),
        .value_o   (step_val),
        .out_bit_o (step_bit)
    );

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
            dir_q    <= DIR_LEFT;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            ov_q     <= ov_d;
            dir_q    <= dir_d;
            arith_q  <= arith_d;
        end
    end

    // Next state: Flush wins over everything and leaves Result/Ov untouched;
    // operands are latched at accept so the bus may change mid-shift.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        ov_d     = ov_q;
        dir_d    = dir_q;
        arith_d  = arith_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.Flush && bus.Start) begin
                    result_d = bus.Data;
                    count_d  = bus.Shamt;
                    dir_d    = bus.Dir;
                    arith_d  = bus.Arith;
                    if (bus.Shamt == '0) begin
                        ov_d    = bus.OvIn;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (bus.Flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = step_val;
                    ov_d     = step_bit;
                    count_d  = count_q - SHAMTW'(1);
                    if (count_q == SHAMTW'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Busy   = (state_q != IDLE);
    assign bus.Done   = (state_q == DONE);
    assign bus.Result = result_q;
    assign bus.Ov     = ov_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with an expected-result queue.
module tb_shift_sequencer;
    import shift_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       ov;
        int         lat;
    } exp_t;

    logic CLK;
    logic ResetN;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    shift_sequencer_if #(.WIDTH(8), .SHAMTW(3)) bus ();

    shift_sequencer #(.WIDTH(8), .SHAMTW(3)) dut (
        .CLK    (CLK),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference shift computed in one step from the operand.
    task automatic model(input logic [7:0] d, input logic [2:0] s, input logic dr,
                         input logic ar, input logic oi,
                         output logic [7:0] r, output logic ov);
        int si;
        si = int'(s);
        if (si == 0) begin
            r = d; ov = oi;
        end else if (dr == DIR_LEFT) begin
            r = d << si; ov = d[8-si];
        end else begin
            r  = ar ? 8'($signed(d) >>> si) : (d >> si);
            ov = d[si-1];
        end
    endtask

    task automatic scramble();
        bus.Data  = 8'($urandom);
        bus.Shamt = 3'($urandom);
        bus.Dir   = 1'($urandom);
        bus.Arith = 1'($urandom);
        bus.OvIn  = 1'($urandom);
    endtask

    // One full operation: push expectation, pulse Start, wait bounded for Done.
    task automatic do_op(input string tag, input logic [7:0] d, input logic [2:0] s,
                         input logic dr, input logic ar, input logic oi,
                         input logic [7:0] er, input logic eo);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge CLK);
        bus.Start = 1'b1; bus.Data = d; bus.Shamt = s;
        bus.Dir = dr; bus.Arith = ar; bus.OvIn = oi;
        e.res = er; e.ov = eo; e.lat = int'(s) + 1;
        sb.push_back(e);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                bus.Start = 1'b0;
                scramble();
            end
            if (bus.Done === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk({tag, "_lat"}, cyc, e.lat);
                chk({tag, "_res"}, bus.Result, e.res);
                chk({tag, "_ov"}, bus.Ov, e.ov);
                chk({tag, "_busy"}, bus.Busy, 1);
            end
        end
        if (!seen) begin
            chk({tag, "_timeout"}, seen, 1);
            void'(sb.pop_front());
        end
        @(negedge CLK);
        chk({tag, "_done_low"}, bus.Done, 0);
        chk({tag, "_idle"}, bus.Busy, 0);
    endtask

    initial begin
        logic [7:0] d, r;
        logic [2:0] s;
        logic       dr, ar, oi, ov;
        int         done_cnt;
        exp_t       e;

        bus.Start = 1'b0; bus.Flush = 1'b0;
        bus.Data = '0; bus.Shamt = '0; bus.Dir = 1'b0; bus.Arith = 1'b0; bus.OvIn = 1'b0;

        // Reset with random inputs and Start asserted
        ResetN = 1'b1;
        #2;
        ResetN = 1'b0;
        scramble();
        bus.Start = 1'b1;
        #1;
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_res", bus.Result, 0);
        chk("rst_ov", bus.Ov, 0);
        repeat (2) @(negedge CLK);
        bus.Start = 1'b0;
        ResetN = 1'b1;

        do_op("left3",  8'b1011_0001, 3'd3, DIR_LEFT,  1'b0, 1'b0, 8'b1000_1000, 1'b1);
        do_op("asr2",   8'h90,        3'd2, DIR_RIGHT, 1'b1, 1'b0, 8'hE4,        1'b0);
        do_op("zero",   8'h5A,        3'd0, DIR_LEFT,  1'b0, 1'b1, 8'h5A,        1'b1);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom); s = 3'($urandom); dr = 1'($urandom);
            ar = 1'($urandom); oi = 1'($urandom);
            model(d, s, dr, ar, oi, r, ov);
            do_op("rand", d, s, dr, ar, oi, r, ov);
        end

        // Max shift with Start held high: one idle cycle, then re-accept
        @(negedge CLK);
        bus.Start = 1'b1; bus.Data = 8'hFF; bus.Shamt = 3'd7;
        bus.Dir = DIR_RIGHT; bus.Arith = 1'b0; bus.OvIn = 1'b0;
        e.res = 8'h01; e.ov = 1'b1; e.lat = 8;
        sb.push_back(e);
        done_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge CLK);
            if (bus.Done === 1'b1) done_cnt++;
        end
        chk("max_early_done", done_cnt, 0);
        @(negedge CLK);
        chk("max_done", bus.Done, 1);
        e = sb.pop_front();
        chk("max_res", bus.Result, e.res);
        chk("max_ov", bus.Ov, e.ov);
        @(negedge CLK);
        chk("max_idle_gap", bus.Busy, 0);
        @(negedge CLK);
        chk("max_reaccept", bus.Busy, 1);
        // Flush beats Start, both mid-shift and in IDLE
        bus.Flush = 1'b1;
        @(negedge CLK);
        chk("flush_start_busy1", bus.Busy, 0);
        @(negedge CLK);
        chk("flush_start_busy2", bus.Busy, 0);
        chk("flush_start_res", bus.Result, 8'hFF);
        bus.Start = 1'b0; bus.Flush = 1'b0;

        // Flush in cycle 2 of a 5-bit shift
        @(negedge CLK);
        bus.Start = 1'b1; bus.Data = 8'h81; bus.Shamt = 3'd5;
        bus.Dir = DIR_LEFT; bus.Arith = 1'b0;
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        chk("flush_busy_before", bus.Busy, 1);
        bus.Flush = 1'b1;
        @(negedge CLK);
        bus.Flush = 1'b0;
        chk("flush_idle", bus.Busy, 0);
        chk("flush_res", bus.Result, 8'h02);
        chk("flush_ov", bus.Ov, 1);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.Done === 1'b1) done_cnt++;
        end
        chk("flush_no_done", done_cnt, 0);

        // Reset pulse mid-shift
        @(negedge CLK);
        bus.Start = 1'b1; bus.Data = 8'hC3; bus.Shamt = 3'd6;
        bus.Dir = DIR_RIGHT; bus.Arith = 1'b1;
        @(negedge CLK);
        bus.Start = 1'b0;
        @(negedge CLK);
        chk("mid_busy", bus.Busy, 1);
        ResetN = 1'b0;
        #1;
        chk("mid_rst_busy", bus.Busy, 0);
        chk("mid_rst_done", bus.Done, 0);
        chk("mid_rst_res", bus.Result, 0);
        chk("mid_rst_ov", bus.Ov, 0);
        @(negedge CLK);
        ResetN = 1'b1;

        do_op("post_rst", 8'h0F, 3'd1, DIR_LEFT, 1'b0, 1'b0, 8'h1E, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
